// File: rtl/calc_pkg.sv
// Shared encodings for the calculator controller and its LED driver.
package calc_pkg;

    localparam int DATA_W = 8;

    // Main state encoding; 5..7 are illegal and recover to ST_INPUT_A.
    typedef enum logic [2:0] {
        ST_INPUT_A = 3'd0,
        ST_INPUT_B = 3'd1,
        ST_RESULT  = 3'd2,
        ST_CALC    = 3'd3,
        ST_ERROR   = 3'd4
    } state_e;

    // Operation select codes.
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

endpackage

// File: rtl/calc_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter, rising-edge pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous button into the clock domain.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it has been stable for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync2 == level) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt   <= '0;
            level <= sync2;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // One-cycle pulse on each rising edge of the accepted level; releases are silent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_d <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            level_d <= level;
            pulse   <= level & ~level_d;
        end
    end

endmodule

// File: rtl/calc_ctrl.sv
// Calculator controller: operand entry FSM plus 1-cycle add/sub and
// 8-iteration shift-add multiply / restoring divide.
module calc_ctrl
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sw,
    input  logic [1:0]        op_sel,
    input  logic              btn_confirm,
    input  logic              btn_clear,
    output logic [2:0]        current_state,
    output logic [DATA_W-1:0] data_saved,
    output logic              overflow,
    output logic              div_zero,
    output logic              busy
);

    logic confirm_pulse;
    logic clear_pulse;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_confirm (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_confirm),
        .pulse (confirm_pulse)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_clear),
        .pulse (clear_pulse)
    );

    state_e              state, state_n;
    logic [DATA_W-1:0]   a_reg, a_n;
    logic [DATA_W-1:0]   b_reg, b_n;
    logic [1:0]          op_reg, op_n;
    // Shared iterative register: {partial product high, multiplier} for mul,
    // {remainder, dividend/quotient} for div.
    logic [2*DATA_W-1:0] acc, acc_n;
    logic [2:0]          iter, iter_n;
    logic [DATA_W-1:0]   data_n;
    logic                ovf_n;
    logic                dz_n;
    logic                busy_n;

    // Single-cycle and per-iteration arithmetic.
    logic [DATA_W:0]     add_sum;
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_step;
    logic [DATA_W:0]     div_shift;
    logic                div_fit;
    logic [DATA_W:0]     div_diff;
    logic [2*DATA_W-1:0] div_step;

    assign add_sum   = {1'b0, a_reg} + {1'b0, b_reg};
    assign mul_sum   = {1'b0, acc[15:8]} + (acc[0] ? {1'b0, a_reg} : 9'd0);
    assign mul_step  = {mul_sum, acc[7:1]};
    assign div_shift = acc[15:7];
    assign div_fit   = (div_shift >= {1'b0, b_reg});
    assign div_diff  = div_shift - {1'b0, b_reg};
    assign div_step  = div_fit ? {div_diff[7:0], acc[6:0], 1'b1}
                               : {div_shift[7:0], acc[6:0], 1'b0};

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_INPUT_A;
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= OP_ADD;
            acc        <= '0;
            iter       <= '0;
            data_saved <= '0;
            overflow   <= 1'b0;
            div_zero   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            a_reg      <= a_n;
            b_reg      <= b_n;
            op_reg     <= op_n;
            acc        <= acc_n;
            iter       <= iter_n;
            data_saved <= data_n;
            overflow   <= ovf_n;
            div_zero   <= dz_n;
            busy       <= busy_n;
        end
    end

    // Next-state and next-output logic; clear overrides everything else.
    always_comb begin
        // NOTE: every output of this block gets a hold value first so no path infers a latch.
        state_n = state;
        a_n     = a_reg;
        b_n     = b_reg;
        op_n    = op_reg;
        acc_n   = acc;
        iter_n  = iter;
        data_n  = data_saved;
        ovf_n   = overflow;
        dz_n    = div_zero;

        if (clear_pulse) begin
            state_n = ST_INPUT_A;
            data_n  = '0;
            ovf_n   = 1'b0;
            dz_n    = 1'b0;
            iter_n  = '0;
        end else begin
            case (state)
                ST_INPUT_A: begin
                    if (confirm_pulse) begin
                        a_n     = sw;
                        data_n  = sw;
                        state_n = ST_INPUT_B;
                    end
                end
                ST_INPUT_B: begin
                    if (confirm_pulse) begin
                        b_n     = sw;
                        op_n    = op_sel;
                        iter_n  = '0;
                        acc_n   = (op_sel == OP_MUL) ? {8'd0, sw} : {8'd0, a_reg};
                        state_n = ST_CALC;
                    end
                end
                ST_CALC: begin
                    case (op_reg)
                        OP_ADD: begin
                            data_n  = add_sum[7:0];
                            ovf_n   = add_sum[8];
                            state_n = ST_RESULT;
                        end
                        OP_SUB: begin
                            data_n  = a_reg - b_reg;
                            ovf_n   = (a_reg < b_reg);
                            state_n = ST_RESULT;
                        end
                        OP_MUL: begin
                            acc_n  = mul_step;
                            iter_n = iter + 3'd1;
                            if (iter == 3'd7) begin
                                data_n  = mul_step[7:0];
                                ovf_n   = |mul_step[15:8];
                                state_n = ST_RESULT;
                            end
                        end
                        default: begin
                            if (b_reg == '0) begin
                                data_n  = '0;
                                ovf_n   = 1'b0;
                                dz_n    = 1'b1;
                                state_n = ST_ERROR;
                            end else begin
                                acc_n  = div_step;
                                iter_n = iter + 3'd1;
                                if (iter == 3'd7) begin
                                    data_n  = div_step[7:0];
                                    ovf_n   = 1'b0;
                                    state_n = ST_RESULT;
                                end
                            end
                        end
                    endcase
                end
                ST_RESULT: begin
                    if (confirm_pulse) begin
                        data_n  = '0;
                        ovf_n   = 1'b0;
                        dz_n    = 1'b0;
                        state_n = ST_INPUT_A;
                    end
                end
                ST_ERROR: begin
                    if (confirm_pulse) begin
                        data_n  = '0;
                        dz_n    = 1'b0;
                        state_n = ST_INPUT_A;
                    end
                end
                default: state_n = ST_INPUT_A;
            endcase
        end

        busy_n = (state_n == ST_CALC);
    end

    assign current_state = state;

endmodule
